store_write_buffer: RTL
=======================

Name: store_write_buffer

Overview:
- Sits directly downstream of the MEM-stage store part-word formatter.
- Takes its zero-extended part-word data (SB/SH/SW), the store width code and the address, and aligns the data onto byte lanes with byte enables.
- Queues stores in a small FIFO and drains them to data memory over a req/ack handshake.
- Back-pressures the pipeline when full; flags loads that hit a pending store.

Parameters:
- DATA_WIDTH, 32, data path width; fixed 4 byte lanes.
- ADDR_WIDTH, 32, byte address width.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- MemWriteM  in  1  store request this cycle.
- StoreSrcM  in  2  store width: 00 SW, 01 SB, 10 SH, 11 illegal.
- ALUResultM  in  ADDR_WIDTH  store/load byte address.
- WritePartDataM  in  DATA_WIDTH  zero-extended part-word data, bits right-aligned.
- MemReadM  in  1  load in MEM this cycle.
- StallStoreM  out  1  store not accepted; pipeline holds MEM.
- LoadHazardM  out  1  load word-address matches a pending store; pipeline holds MEM.
- MisalignM  out  1  store dropped: misaligned or illegal width.
- DMemReq  out  1  write request to data memory.
- DMemAddr  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0.
- DMemWData  out  DATA_WIDTH  lane-aligned write data.
- DMemBE  out  4  byte enables.
- DMemAck  in  1  memory accepted the current write.
- BufEmpty  out  1  no pending stores (used for fences).

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - Read/write pointers and count go to 0; the entire state is cleared.
  - Outputs the following cycle: DMemReq=0, DMemAddr=0, DMemWData=0, DMemBE=0, BufEmpty=1.
  - Reset mid-transaction discards all entries, including an unacked head; any DMemAck during reset is ignored.
- Lane alignment and legality; a = ALUResultM[1:0]:
  - SB: BE = 0001<<a; data = WritePartDataM[7:0]<<(8a). Always legal.
  - SH: legal only if a[0]=0. BE = 0011<<a; data = WritePartDataM[15:0]<<(8a).
  - SW: legal only if a=00. BE = 1111; data unchanged.
  - StoreSrcM=11 is always illegal.
  - An illegal store with MemWriteM=1 gives MisalignM=1 (combinational), is not enqueued and does not stall.
- Enqueue:
  - Occurs when MemWriteM=1, the store is legal and count<DEPTH.
  - Entry {word addr, data, BE} is written at the write pointer; the pointer wraps modulo DEPTH.
- Full:
  - StallStoreM = MemWriteM & legal & (count==DEPTH), combinational.
  - No enqueue while full, even if DMemAck pops in the same cycle (conservative; the store retries next cycle).
- Drain:
  - DMemReq = (count!=0), registered from next-state.
  - DMemAddr/DMemWData/DMemBE present the head entry and stay stable while DMemReq=1 and DMemAck=0.
  - DMemAck=1 with DMemReq=1 pops the head. The next entry, if any, is presented the following cycle with DMemReq still high (back-to-back).
  - DMemAck while DMemReq=0 is ignored.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Minimum latency: a store accepted at edge N gives DMemReq=1 after edge N when the buffer was empty.
- LoadHazardM:
  - Equals MemReadM & (some valid entry's word address == ALUResultM[ADDR_WIDTH-1:2]), combinational.
  - The store being enqueued this same cycle is excluded, since a load and a store cannot share the MEM stage.
  - The head entry counts until the edge at which its ack pops it.
- BufEmpty = (count==0), registered.
- Count width is clog2(DEPTH)+1 and must never exceed DEPTH.

Decomposition:
- Shared package riscv_mem_pkg:
  - store_src_e enum (SW=00, SB=01, SH=10), byte-lane count 4.
  - store_entry_t struct {word_addr, data, be}.
- Sub-module store_lane_align: the combinational shift/BE/legality logic, reusable by a future load extender.
- Top block: FIFO storage, pointers/count, drain handshake, hazard compare.

Test Plan:
- Reset, then SB addr 0x1003, WritePartDataM=0x000000AB, DMemAck held 1 → next cycle DMemReq=1, DMemAddr=0x1000, DMemWData=0xAB000000, DMemBE=1000; popped at the following edge, BufEmpty=1.
- SH addr 0x2001 → MisalignM=1, no enqueue, BufEmpty stays 1. StoreSrcM=11 at 0x2000 → MisalignM=1.
- Five SW (0x10, 0x14, 0x18, 0x1C, 0x20) on consecutive cycles, DMemAck=0 → fifth cycle StallStoreM=1, count=4. Raise ack for one cycle → 0x10 drains; the retried 0x20 is accepted next cycle; drain order is 0x14, 0x18, 0x1C, 0x20.
- Pending SW at 0x300, MemReadM=1 with address 0x302 → LoadHazardM=1. Load at 0x304 → LoadHazardM=0. After ack pops 0x300 → hazard clears.
- Push and pop in the same cycle at count=2 → count remains 2, FIFO order preserved across pointer wrap (run 10 stores through DEPTH=4).
- reset_n=0 while DMemReq=1 with 3 entries → next cycle DMemReq=0, BufEmpty=1; an ack asserted during reset has no effect.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared memory-stage types: store width codes, byte-lane count and the
// queued store entry format used by the store write buffer.
package riscv_mem_pkg;

   localparam int NUM_LANES  = 4;
   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;

   typedef enum logic [1:0] {
      SW = 2'b00,
      SB = 2'b01,
      SH = 2'b10
   } store_src_e;

   typedef struct packed {
      logic [MEM_ADDR_W-3:0] word_addr;
      logic [MEM_DATA_W-1:0] data;
      logic [NUM_LANES-1:0]  be;
   } store_entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Places right-aligned part-word data onto byte lanes and derives byte
// enables plus legality from the width code and the address byte offset.
module store_lane_align
   import riscv_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [1:0]            store_src,
   input  logic [1:0]            byte_off,
   input  logic [DATA_WIDTH-1:0] part_data,
   output logic                  legal,
   output logic [NUM_LANES-1:0]  be,
   output logic [DATA_WIDTH-1:0] lane_data
);

   always_comb begin
      legal     = 1'b0;
      be        = '0;
      lane_data = '0;
      case (store_src_e'(store_src))
         SB: begin
            legal     = 1'b1;
            be        = 4'b0001 << byte_off;
            lane_data = DATA_WIDTH'(part_data[7:0]) << {byte_off, 3'b000};
         end
         SH: begin
            legal     = ~byte_off[0];
            be        = 4'b0011 << byte_off;
            lane_data = DATA_WIDTH'(part_data[15:0]) << {byte_off, 3'b000};
         end
         SW: begin
            legal     = (byte_off == 2'b00);
            be        = 4'b1111;
            lane_data = part_data;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: aligns MEM-stage stores onto byte lanes, queues them in
// a small FIFO and drains them to data memory over a req/ack handshake.
module store_write_buffer
   import riscv_mem_pkg::*;
#(
   parameter int DATA_WIDTH = MEM_DATA_W,
   parameter int ADDR_WIDTH = MEM_ADDR_W,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  MemWriteM,
   input  logic [1:0]            StoreSrcM,
   input  logic [ADDR_WIDTH-1:0] ALUResultM,
   input  logic [DATA_WIDTH-1:0] WritePartDataM,
   input  logic                  MemReadM,
   output logic                  StallStoreM,
   output logic                  LoadHazardM,
   output logic                  MisalignM,
   output logic                  DMemReq,
   output logic [ADDR_WIDTH-1:0] DMemAddr,
   output logic [DATA_WIDTH-1:0] DMemWData,
   output logic [3:0]            DMemBE,
   input  logic                  DMemAck,
   output logic                  BufEmpty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   store_entry_t          mem [DEPTH];
   logic [PW-1:0]         wptr, rptr, rptr_n, off;
   logic [CW-1:0]         count, count_n;
   logic                  legal, full, push, pop, hit;
   logic [NUM_LANES-1:0]  al_be;
   logic [DATA_WIDTH-1:0] al_data;
   store_entry_t          new_entry, head_n;

   store_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .store_src (StoreSrcM),
      .byte_off  (ALUResultM[1:0]),
      .part_data (WritePartDataM),
      .legal     (legal),
      .be        (al_be),
      .lane_data (al_data)
   );

   // A full buffer refuses stores even when the head pops this cycle.
   assign full        = (count == CW'(DEPTH));
   assign MisalignM   = MemWriteM & ~legal;
   assign StallStoreM = MemWriteM & legal & full;
   assign push        = MemWriteM & legal & ~full;
   assign pop         = DMemReq & DMemAck;
   assign rptr_n      = rptr + PW'(pop);
   assign new_entry   = '{word_addr: ALUResultM[ADDR_WIDTH-1:2], data: al_data, be: al_be};

   always_comb begin
      count_n = count;
      if (push && !pop)
         count_n = count + CW'(1);
      else if (!push && pop)
         count_n = count - CW'(1);
   end

   // The entry written this edge becomes the head when it lands on rptr_n.
   always_comb begin
      head_n = '0;
      if (count_n != '0) begin
         if (push && (wptr == rptr_n))
            head_n = new_entry;
         else
            head_n = mem[rptr_n];
      end
   end

   always_comb begin
      hit = 1'b0;
      off = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = PW'(i) - rptr;
         if (({1'b0, off} < count) && (mem[i].word_addr == ALUResultM[ADDR_WIDTH-1:2]))
            hit = 1'b1;
      end
   end

   assign LoadHazardM = MemReadM & hit;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         DMemReq   <= 1'b0;
         BufEmpty  <= 1'b1;
         DMemAddr  <= '0;
         DMemWData <= '0;
         DMemBE    <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push)
            mem[wptr] <= new_entry;
         wptr      <= wptr + PW'(push);
         rptr      <= rptr_n;
         count     <= count_n;
         DMemReq   <= (count_n != '0);
         BufEmpty  <= (count_n == '0);
         DMemAddr  <= {head_n.word_addr, 2'b00};
         DMemWData <= head_n.data;
         DMemBE    <= head_n.be;
      end
   end

endmodule
